// File: rtl/auto_nav_ctrl_if.sv
// Signal bundle between the obstacle-avoidance controller and its environment:
// auto-mode enable and debounced barrier flags in, motion commands and status out.
interface auto_nav_ctrl_if;
  logic       start;
  logic       det_front;
  logic       det_left;
  logic       det_right;
  logic       det_back;
  logic       move_fwd;
  logic       move_back;
  logic       turn_left;
  logic       turn_right;
  logic [2:0] state;
  logic [7:0] turn_cnt;

  // Environment side: drives mode and sensor flags, observes commands.
  modport master (
    output start, det_front, det_left, det_right, det_back,
    input  move_fwd, move_back, turn_left, turn_right, state, turn_cnt
  );

  // Controller side.
  modport slave (
    input  start, det_front, det_left, det_right, det_back,
    output move_fwd, move_back, turn_left, turn_right, state, turn_cnt
  );
endinterface

// File: rtl/auto_nav_ctrl.sv
// Obstacle-avoidance controller: cruises forward, settles on a front barrier,
// turns away (right preferred, then left, then about-face), re-checks, resumes.
// Optional macro REVERSE_ESCAPE_EN: a dead end first reverses for
// REVERSE_CYCLES (aborted early by a rear barrier) before turning around.
module auto_nav_ctrl #(
  parameter int SETTLE_CYCLES  = 50_000_000,
  parameter int TURN_CYCLES    = 40_000_000,
  parameter int REVERSE_CYCLES = 30_000_000,
  parameter int CNT_W          = 27
) (
  input  logic           clk,
  input  logic           rst,
  auto_nav_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FORWARD     = 3'd1,
    SETTLE      = 3'd2,
    TURN_R      = 3'd3,
    TURN_L      = 3'd4,
    TURN_AROUND = 3'd5,
    CHECK       = 3'd6,
    REVERSE     = 3'd7
  } state_t;

  // Timer counts down from (duration - 1); the state's last cycle is timer == 0.
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD    = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] AROUND_LOAD  = CNT_W'(2 * TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] REVERSE_LOAD = CNT_W'(REVERSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] TIMER_ONE    = CNT_W'(1);

  state_t           cur_state;
  state_t           nxt_state;
  state_t           dead_end_state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] nxt_timer;
  logic [7:0]       cnt;
  logic             cnt_inc;
  logic             expired;
  logic             fwd, back, left, right;
  logic             nxt_fwd, nxt_back, nxt_left, nxt_right;

  assign expired = (timer == TIMER_ZERO);

`ifdef REVERSE_ESCAPE_EN
  // A dead end reverses first unless something is already behind us.
  assign dead_end_state = bus.det_back ? TURN_AROUND : REVERSE;
`else
  assign dead_end_state = TURN_AROUND;
`endif

  // Next-state and timer-load logic; losing auto mode overrides everything.
  always_comb begin
    nxt_state = cur_state;
    nxt_timer = expired ? timer : (timer - TIMER_ONE);
    cnt_inc   = 1'b0;
    if (!bus.start) begin
      nxt_state = IDLE;
      nxt_timer = TIMER_ZERO;
    end else begin
      case (cur_state)
        IDLE: begin
          nxt_state = FORWARD;
          nxt_timer = TIMER_ZERO;
        end
        FORWARD: begin
          if (bus.det_front) begin
            nxt_state = SETTLE;
            nxt_timer = SETTLE_LOAD;
          end else begin
            nxt_state = FORWARD;
          end
        end
        SETTLE: begin
          // Flags only matter on the final settle cycle.
          if (!expired) begin
            nxt_state = SETTLE;
          end else if (!bus.det_right) begin
            nxt_state = TURN_R;
            nxt_timer = TURN_LOAD;
          end else if (!bus.det_left) begin
            nxt_state = TURN_L;
            nxt_timer = TURN_LOAD;
          end else if (dead_end_state == REVERSE) begin
            nxt_state = REVERSE;
            nxt_timer = REVERSE_LOAD;
          end else begin
            nxt_state = TURN_AROUND;
            nxt_timer = AROUND_LOAD;
          end
        end
        TURN_R, TURN_L, TURN_AROUND: begin
          if (expired) begin
            nxt_state = CHECK;
            nxt_timer = TIMER_ZERO;
            cnt_inc   = 1'b1;
          end else begin
            nxt_state = cur_state;
          end
        end
        CHECK: begin
          if (bus.det_front) begin
            nxt_state = SETTLE;
            nxt_timer = SETTLE_LOAD;
          end else begin
            nxt_state = FORWARD;
            nxt_timer = TIMER_ZERO;
          end
        end
        REVERSE: begin
          // A rear barrier cuts the reverse short.
          if (expired || bus.det_back) begin
            nxt_state = TURN_AROUND;
            nxt_timer = AROUND_LOAD;
          end else begin
            nxt_state = REVERSE;
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_timer = TIMER_ZERO;
        end
      endcase
    end
  end

  // Motion decode from the next state, so registered commands line up with the state register.
  always_comb begin
    nxt_fwd   = 1'b0;
    nxt_back  = 1'b0;
    nxt_left  = 1'b0;
    nxt_right = 1'b0;
    case (nxt_state)
      FORWARD:             nxt_fwd   = 1'b1;
      TURN_R, TURN_AROUND: nxt_right = 1'b1;
      TURN_L:              nxt_left  = 1'b1;
      REVERSE:             nxt_back  = 1'b1;
      default: begin
        nxt_fwd   = 1'b0;
        nxt_back  = 1'b0;
        nxt_left  = 1'b0;
        nxt_right = 1'b0;
      end
    endcase
  end

  // State register, duration timer and saturating turn counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= IDLE;
      timer     <= TIMER_ZERO;
      cnt       <= 8'd0;
    end else begin
      cur_state <= nxt_state;
      timer     <= nxt_timer;
      if (cnt_inc && (cnt != 8'hFF)) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Registered motion commands.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd   <= 1'b0;
      back  <= 1'b0;
      left  <= 1'b0;
      right <= 1'b0;
    end else begin
      fwd   <= nxt_fwd;
      back  <= nxt_back;
      left  <= nxt_left;
      right <= nxt_right;
    end
  end

  assign bus.move_fwd   = fwd;
  assign bus.move_back  = back;
  assign bus.turn_left  = left;
  assign bus.turn_right = right;
  assign bus.state      = cur_state;
  assign bus.turn_cnt   = cnt;

endmodule

// File: tb/tb_auto_nav_ctrl.sv
// Self-checking bench for auto_nav_ctrl: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a cycle-age reference model.
module tb_auto_nav_ctrl;
  localparam int S = 4;
  localparam int T = 8;
  localparam int R = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  auto_nav_ctrl_if bus ();

  auto_nav_ctrl #(
    .SETTLE_CYCLES(S), .TURN_CYCLES(T), .REVERSE_CYCLES(R), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Reference model: state name plus how many cycles we have been in it.
  int m_state = 0;
  int m_age   = 1;
  int m_cnt   = 0;

  task automatic model_step();
    int nxt;
    nxt = m_state;
    if (rst) begin
      m_state = 0; m_age = 1; m_cnt = 0;
      return;
    end
    if (!bus.start) nxt = 0;
    else begin
      case (m_state)
        0: nxt = 1;
        1: if (bus.det_front) nxt = 2;
        2: if (m_age == S) begin
             if (!bus.det_right) nxt = 3;
             else if (!bus.det_left) nxt = 4;
             else begin
`ifdef REVERSE_ESCAPE_EN
               nxt = bus.det_back ? 5 : 7;
`else
               nxt = 5;
`endif
             end
           end
        3, 4: if (m_age == T) begin nxt = 6; if (m_cnt < 255) m_cnt++; end
        5: if (m_age == 2 * T) begin nxt = 6; if (m_cnt < 255) m_cnt++; end
        6: nxt = bus.det_front ? 2 : 1;
        7: if (bus.det_back || m_age == R) nxt = 5;
        default: nxt = 0;
      endcase
    end
    m_age   = (nxt == m_state) ? m_age + 1 : 1;
    m_state = nxt;
  endtask

  task automatic check_model(string tag);
    logic [3:0] mot;
    logic [3:0] exp;
    mot = {bus.move_fwd, bus.move_back, bus.turn_left, bus.turn_right};
    exp = {m_state == 1, m_state == 7, m_state == 4, (m_state == 3) || (m_state == 5)};
    n_tests++;
    if (bus.state !== 3'(m_state) || mot !== exp || bus.turn_cnt !== 8'(m_cnt) || $countones(mot) > 1) begin
      n_fail++;
      $display("FAIL %s: got state=%0d motion=%b cnt=%0d, expected state=%0d motion=%b cnt=%0d",
               tag, bus.state, mot, bus.turn_cnt, m_state, exp, m_cnt);
    end
  endtask

  task automatic expect_eq(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(logic r, logic s, logic f, logic l, logic rt, logic b);
    rst = r; bus.start = s; bus.det_front = f; bus.det_left = l;
    bus.det_right = rt; bus.det_back = b;
  endtask

  task automatic tick(string tag = "model");
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  // Counts cycles spent in state st, starting from a cycle already showing st.
  task automatic measure(input int st, output int n);
    n = 0;
    while (int'(bus.state) == st && n < 100) begin
      n++;
      tick("measure");
    end
  endtask

  typedef struct {
    logic       r, s, f, l, rt, b;
    logic [2:0] st;
    logic [3:0] mot;   // {fwd, back, left, right}
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic s, logic f, logic l, logic rt, logic b,
                              logic [2:0] st, logic [3:0] mot, logic [7:0] cnt);
    vec_t v;
    v.r = r; v.s = s; v.f = f; v.l = l; v.rt = rt; v.b = b;
    v.st = st; v.mot = mot; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  initial begin
    int n;
    int c0;
    logic [3:0] mot;

    // Reset, start, front barrier, 4-cycle settle with mid-settle flag noise,
    // 8-cycle right turn with ignored flags, check, resume forward.
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 8'd0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 8'd0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 4'b1000, 8'd0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 4'b1000, 8'd0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 4'b0000, 8'd0);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 4'b0000, 8'd0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 4'b0001, 8'd0);
    for (int i = 0; i < 7; i++) add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 4'b0001, 8'd0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 4'b0000, 8'd1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 4'b1000, 8'd1);

    foreach (vecs[i]) begin
      set_in(vecs[i].r, vecs[i].s, vecs[i].f, vecs[i].l, vecs[i].rt, vecs[i].b);
      @(posedge clk);
      model_step();
      #1;
      mot = {bus.move_fwd, bus.move_back, bus.turn_left, bus.turn_right};
      n_tests++;
      if (bus.state !== vecs[i].st || mot !== vecs[i].mot || bus.turn_cnt !== vecs[i].cnt) begin
        n_fail++;
        $display("FAIL vec[%0d]: got state=%0d motion=%b cnt=%0d, expected state=%0d motion=%b cnt=%0d",
                 i, bus.state, mot, bus.turn_cnt, vecs[i].st, vecs[i].mot, vecs[i].cnt);
      end
    end

    // Right blocked, left open: left turn, front still blocked at check -> settle again.
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick("to_settle");
    measure(2, n);        expect_eq("settle_len", n, S);
    expect_eq("turn_l_state", int'(bus.state), 4);
    expect_eq("turn_l_out", int'(bus.turn_left), 1);
    measure(4, n);        expect_eq("turn_l_len", n, T);
    expect_eq("check_state", int'(bus.state), 6);
    expect_eq("cnt_after_l", int'(bus.turn_cnt), 2);
    tick("recheck");
    expect_eq("recheck_settle", int'(bus.state), 2);

    // Dead end.
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    measure(2, n);        expect_eq("dead_settle_len", n, S);
`ifdef REVERSE_ESCAPE_EN
    expect_eq("reverse_state", int'(bus.state), 7);
    expect_eq("reverse_out", int'(bus.move_back), 1);
    measure(7, n);        expect_eq("reverse_len", n, R);
`endif
    expect_eq("around_state", int'(bus.state), 5);
    expect_eq("around_out", int'(bus.turn_right), 1);
    measure(5, n);        expect_eq("around_len", n, 2 * T);
    expect_eq("around_check", int'(bus.state), 6);
    expect_eq("cnt_after_around", int'(bus.turn_cnt), 3);

`ifdef REVERSE_ESCAPE_EN
    // Rear barrier raised in reverse cycle 3 aborts into turn-around next cycle.
    tick("to_settle2");
    measure(2, n);        expect_eq("settle2_len", n, S);
    tick("rev_c2");
    tick("rev_c3");
    bus.det_back = 1'b1;
    tick("rev_abort");
    expect_eq("rev_abort_state", int'(bus.state), 5);
    bus.det_back = 1'b0;
    measure(5, n);        expect_eq("around2_len", n, 2 * T);
`endif

    // start dropped at turn cycle 5 aborts at once; turn count is held.
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick("to_settle3");
    measure(2, n);
    expect_eq("abort_turn_state", int'(bus.state), 3);
    for (int i = 0; i < 4; i++) tick("turn_cycles");
    c0 = m_cnt;
    bus.start = 1'b0;
    tick("abort");
    expect_eq("abort_state", int'(bus.state), 0);
    expect_eq("abort_motion", int'({bus.move_fwd, bus.move_back, bus.turn_left, bus.turn_right}), 0);
    expect_eq("abort_cnt", int'(bus.turn_cnt), c0);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("restart");
    expect_eq("restart_fwd", int'(bus.state), 1);

    // Saturation: ~300 right turns back to back.
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300 * (S + T + 1); i++) tick("sat_run");
    expect_eq("cnt_saturated", int'(bus.turn_cnt), 255);
    rst = 1'b1;
    tick("rst_clear");
    expect_eq("rst_cnt", int'(bus.turn_cnt), 0);
    expect_eq("rst_state", int'(bus.state), 0);

    // Randomized run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom % 400) == 0, ($urandom % 60) != 0, ($urandom % 3) == 0,
             1'($urandom), 1'($urandom), ($urandom % 4) == 0);
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
